// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Program-counter and fetch-sequencing stage placed directly in front of a
// combinational instruction memory. Generates the fetch address, advances it
// sequentially or jumps through a small loadable branch-target table, freezes
// on stall/halt and runs a start/done handshake with the surrounding top level.
//
// Handshake: start is a level sampled only while idle or halted; a run begins
// on the edge where start=1 is seen. running stays high for the whole run and
// done stays high from the halt edge until the edge that accepts the next start.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset (clears state and LUT)
//   start        in   begin a run (IDLE/HALT only)
//   stall        in   freeze pc/count for this cycle
//   halt         in   halt instruction at current pc
//   branch_en    in   branch instruction at current pc
//   branch_taken in   branch condition result
//   lut_sel      in   branch-target table read index
//   lut_we       in   branch-target table write enable
//   lut_waddr    in   branch-target table write index
//   lut_wdata    in   branch-target table write data (absolute target)
//   pc           out  current fetch address
//   running      out  high in RUN
//   done         out  high in HALT
//   instr_count  out  saturating count of non-stalled RUN cycles
//   dbg_state    out  raw FSM state for observation
module pc_fetch_unit #(
  parameter int                 PC_BITS   = 12,
  parameter logic [PC_BITS-1:0] START_PC  = '0,
  parameter int                 LUT_DEPTH = 8,
  parameter int                 CNT_BITS  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stall,
  input  logic                halt,
  input  logic                branch_en,
  input  logic                branch_taken,
  input  logic [2:0]          lut_sel,
  input  logic                lut_we,
  input  logic [2:0]          lut_waddr,
  input  logic [PC_BITS-1:0]  lut_wdata,
  output logic [PC_BITS-1:0]  pc,
  output logic                running,
  output logic                done,
  output logic [CNT_BITS-1:0] instr_count,
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]          r_state;
  logic [PC_BITS-1:0]  r_pc;
  logic [CNT_BITS-1:0] r_cnt;
  logic [PC_BITS-1:0]  r_lut [LUT_DEPTH];

  logic [CNT_BITS-1:0] w_cnt_next;
  logic                w_take_branch;

  // Counter sticks at all-ones instead of wrapping.
  assign w_cnt_next    = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_take_branch = branch_en & branch_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
      for (int i = 0; i < LUT_DEPTH; i++) begin
        r_lut[i] <= '0;
      end
    end else begin
      // The branch read below sees the pre-edge table contents, so a write
      // to the same index only becomes visible on the following cycle.
      if (lut_we) begin
        r_lut[lut_waddr] <= lut_wdata;
      end
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            r_state <= S_RUN;
            r_pc    <= START_PC;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          // Stall outranks everything; the decoder re-presents its events.
          if (!stall) begin
            r_cnt <= w_cnt_next;
            if (halt) begin
              r_state <= S_HALT;
            end else if (w_take_branch) begin
              r_pc <= r_lut[lut_sel];
            end else begin
              r_pc <= r_pc + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pc          = r_pc;
  assign instr_count = r_cnt;
  assign running     = (r_state == S_RUN);
  assign done        = (r_state == S_HALT);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam int PC_BITS  = 12;
  localparam int CNT_BITS = 8;   // narrow counter so saturation is reachable
  localparam int PC_MOD   = 1 << PC_BITS;
  localparam int CNT_MAX  = (1 << CNT_BITS) - 1;

  // clock / reset
  logic clk = 0;
  always #5 clk = ~clk;

  logic                reset, start, stall, halt, branch_en, branch_taken;
  logic [2:0]          lut_sel, lut_waddr;
  logic                lut_we;
  logic [PC_BITS-1:0]  lut_wdata;
  logic [PC_BITS-1:0]  pc;
  logic                running, done;
  logic [CNT_BITS-1:0] instr_count;
  logic [1:0]          dbg_state;

  pc_fetch_unit #(.PC_BITS(PC_BITS), .START_PC('0), .LUT_DEPTH(8), .CNT_BITS(CNT_BITS)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .branch_en(branch_en), .branch_taken(branch_taken), .lut_sel(lut_sel),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .pc(pc), .running(running), .done(done), .instr_count(instr_count),
    .dbg_state(dbg_state)
  );

  // reference model: run/done flags, integer pc and count, table as int array
  bit m_running, m_done;
  int m_pc, m_cnt;
  int m_lut [8];

  int total = 0;
  int bad   = 0;

  // scoreboard: expected pc sequence for the basic run
  logic [PC_BITS-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    reset = 0; start = 0; stall = 0; halt = 0; branch_en = 0; branch_taken = 0;
    lut_sel = 0; lut_we = 0; lut_waddr = 0; lut_wdata = 0;
  endtask

  // Advance the model using the inputs currently applied.
  task automatic model_step();
    int target;
    target = m_lut[lut_sel];
    if (reset) begin
      m_running = 0; m_done = 0; m_pc = 0; m_cnt = 0;
      foreach (m_lut[i]) m_lut[i] = 0;
      return;
    end
    if (!m_running) begin
      if (start) begin
        m_running = 1; m_done = 0; m_pc = 0; m_cnt = 0;
      end
    end else if (!stall) begin
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      if (halt) begin
        m_running = 0; m_done = 1;
      end else if (branch_en && branch_taken) begin
        m_pc = target;
      end else begin
        m_pc = (m_pc + 1) % PC_MOD;
      end
    end
    if (lut_we) m_lut[lut_waddr] = lut_wdata;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
    chk({tag, ".running"}, 32'(running), 32'(m_running));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".count"}, 32'(instr_count), 32'(m_cnt));
  endtask

  // driver: one clock with current inputs, then compare
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic lut_load(input int idx, input int val);
    idle_inputs();
    lut_we = 1; lut_waddr = 3'(idx); lut_wdata = PC_BITS'(val);
    tick("lut_load");
    idle_inputs();
  endtask

  task automatic do_start();
    idle_inputs(); start = 1;
    tick("start");
    idle_inputs();
  endtask

  task automatic branch(input int sel, input bit taken);
    idle_inputs(); branch_en = 1; branch_taken = taken; lut_sel = 3'(sel);
    tick("branch");
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_running = 0; m_done = 0; m_pc = 0; m_cnt = 0;
    foreach (m_lut[i]) m_lut[i] = 0;

    // reset state
    reset = 1;
    tick("reset");
    reset = 1;
    tick("reset2");
    idle_inputs();

    // basic run: pc 0..5, fixed expectations through the scoreboard queue
    for (int i = 0; i <= 5; i++) exp_q.push_back(PC_BITS'(i));
    do_start();
    chk("basic.pc0", 32'(pc), 32'(exp_q.pop_front()));
    for (int i = 0; i < 5; i++) begin
      tick("basic");
      chk("basic.seq", 32'(pc), 32'(exp_q.pop_front()));
    end
    chk("basic.count5", 32'(instr_count), 32'd5);
    chk("basic.running", 32'(running), 32'd1);
    start = 1; tick("start_in_run"); idle_inputs();   // ignored in RUN

    // taken / not-taken branch with table loaded in IDLE
    reset = 1; tick("reset3"); idle_inputs();
    lut_load(3, 'h100);
    lut_load(1, 'h020);
    lut_load(7, 'hFFE);
    do_start();
    tick("adv"); tick("adv");                        // pc=2
    branch(3, 0);
    chk("nt.pc3", 32'(pc), 32'h3);
    branch(3, 1);
    chk("taken.pc100", 32'(pc), 32'h100);

    // table write and taken branch on the same index: old value used
    idle_inputs(); branch_en = 1; branch_taken = 1; lut_sel = 1;
    lut_we = 1; lut_waddr = 1; lut_wdata = 'h055;
    tick("collide");
    chk("collide.old", 32'(pc), 32'h020);
    branch(1, 1);
    chk("collide.new", 32'(pc), 32'h055);

    // stall with pending halt/branch, then release into halt
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); stall = 1; halt = 1; branch_en = 1; branch_taken = 1; lut_sel = 3;
      tick("stall");
    end
    chk("stall.pc", 32'(pc), 32'h055);
    idle_inputs(); halt = 1; tick("halt_rel"); idle_inputs();
    chk("halt.done", 32'(done), 32'd1);
    tick("halt_hold"); tick("halt_hold");

    // restart from HALT
    do_start();
    chk("restart.pc", 32'(pc), 32'h0);
    chk("restart.done", 32'(done), 32'd0);

    // halt outranks a taken branch
    for (int i = 0; i < 9; i++) tick("adv");       // pc=9
    idle_inputs(); halt = 1; branch_en = 1; branch_taken = 1; lut_sel = 3;
    tick("prio"); idle_inputs();
    chk("prio.pc9", 32'(pc), 32'h9);

    // wrap 4095 -> 0
    do_start();
    branch(7, 1);
    tick("to4095");
    chk("wrap.pcmax", 32'(pc), 32'hFFF);
    tick("wrap");
    chk("wrap.pc0", 32'(pc), 32'h0);

    // counter saturation
    for (int i = 0; i < CNT_MAX + 20; i++) tick("sat");
    chk("sat.count", 32'(instr_count), 32'(CNT_MAX));

    // reset mid-run clears table; a later taken branch lands on 0
    do_start();
    branch(3, 1);                                  // pc=0x100 in this run
    idle_inputs(); reset = 1; lut_we = 1; lut_waddr = 2; lut_wdata = 'h777;
    tick("midreset"); idle_inputs();
    do_start();
    tick("adv");
    branch(3, 1);
    chk("lut_cleared3", 32'(pc), 32'h0);
    tick("adv");
    branch(2, 1);
    chk("lut_dropped2", 32'(pc), 32'h0);

    // randomized phase against the model
    for (int n = 0; n < 3000; n++) begin
      idle_inputs();
      reset        = ($urandom_range(0, 199) == 0);
      start        = ($urandom_range(0, 7) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      halt         = ($urandom_range(0, 39) == 0);
      branch_en    = ($urandom_range(0, 3) == 0);
      branch_taken = $urandom_range(0, 1);
      lut_sel      = 3'($urandom_range(0, 7));
      lut_we       = ($urandom_range(0, 5) == 0);
      lut_waddr    = 3'($urandom_range(0, 7));
      lut_wdata    = PC_BITS'($urandom_range(0, PC_MOD - 1));
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
